// File: rtl/sat_pkg.sv
// Shared definitions for the saturating accumulator: FSM state encoding
// and the signed saturation bounds expressed as functions of word width.
package sat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Largest value of a w-bit two's-complement word: 2^(w-1)-1
  function automatic longint satMax(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value of a w-bit two's-complement word: -2^(w-1)
  function automatic longint satMin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_addsub_core.sv
// Combinational saturating add/subtract of two signed W-bit words.
// The exact result is formed one bit wider so that no overflow is lost,
// then clamped back into the W-bit range with a flag when clamping occurs.
module sat_addsub_core
  import sat_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         clamp
);

  localparam logic signed [W:0] MAX_EXT = (W + 1)'(satMax(W));
  localparam logic signed [W:0] MIN_EXT = (W + 1)'(satMin(W));

  logic signed [W:0] aExt;
  logic signed [W:0] bExt;
  logic signed [W:0] exact;

  assign aExt = {a[W-1], a};
  assign bExt = {b[W-1], b};

  // Exact W+1-bit sum/difference followed by clamping to the W-bit range
  always_comb begin
    exact = sub ? (aExt - bExt) : (aExt + bExt);
    y     = exact[W-1:0];
    clamp = 1'b0;
    if (exact > MAX_EXT) begin
      y     = MAX_EXT[W-1:0];
      clamp = 1'b1;
    end else if (exact < MIN_EXT) begin
      y     = MIN_EXT[W-1:0];
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/sat_accum.sv
// Frame-based saturating fixed-point accumulator.
// Operands stream in with valid/ready; the running sum is clamped at every
// step. After the last operand the result is held on the output handshake
// until taken, during which no new operands are accepted.
// Optional build macro SAT_ACCUM_STATS_EN adds a 16-bit sat_frames port
// counting delivered frames that saw at least one clamp.
module sat_accum
  import sat_pkg::*;
#(
  parameter int INT   = 8,
  parameter int FRAC  = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT+FRAC-1:0]   in_data,
  input  logic                  in_sub,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT+FRAC-1:0]   out_sum,
  output logic                  out_sat,
  output logic [CNT_W-1:0]      out_count
`ifdef SAT_ACCUM_STATS_EN
  ,
  output logic [15:0]           sat_frames
`endif
);

  localparam int W = INT + FRAC;

  state_e state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic             deliver;
  logic [W-1:0]     coreA;
  logic [W-1:0]     coreY;
  logic             coreClamp;

  assign accept  = in_valid && in_ready;
  assign deliver = (state_q == HOLD) && out_ready;

  // A new frame starts from zero; within a frame the running sum feeds back
  assign coreA = (state_q == ACC) ? acc_q : '0;

  sat_addsub_core #(
    .W(W)
  ) u_core (
    .a    (coreA),
    .b    (in_data),
    .sub  (in_sub),
    .y    (coreY),
    .clamp(coreClamp)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: last operand ends the frame, output transfer frees it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = in_last ? HOLD : ACC;
      ACC:     if (accept && in_last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: accumulate on acceptance, clear on delivery
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (accept) begin
      acc_d = coreY;
      if (state_q == IDLE) begin
        count_d = CNT_W'(1);
        sat_d   = coreClamp;
      end else begin
        count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
        sat_d   = sat_q | coreClamp;
      end
    end else if (deliver) begin
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end
  end

  // Datapath registers; a reset mid-frame simply discards the partial sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  // Handshake and result outputs, zeroed whenever no result is offered
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    out_sum   = '0;
    out_sat   = 1'b0;
    out_count = '0;
    if (state_q == HOLD) begin
      out_sum   = acc_q;
      out_sat   = sat_q;
      out_count = count_q;
    end
  end

`ifdef SAT_ACCUM_STATS_EN
  logic [15:0] sat_frames_q;

  // Count delivered frames that clamped, sticking at the maximum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_frames_q <= '0;
    end else if (deliver && sat_q && (sat_frames_q != 16'hFFFF)) begin
      sat_frames_q <= sat_frames_q + 16'd1;
    end
  end

  assign sat_frames = sat_frames_q;
`endif

endmodule
